// File: rtl/clock_divider_n.sv
// rtl/clock_divider_n.sv - runtime-programmable integer clock divider
//
// Divides clk by a ratio N in [2, 2^CNT_W-1]. N is requested through a shadow
// register and only takes effect at a period boundary while running.
//
// Optional build macro: CLK_DIV_ODD_DUTY50_EN
//   Adds a negedge stage so odd ratios produce an exact 50% duty clk_out.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   run enable; low parks the divider idle
//   div_val  in   requested ratio N (CNT_W bits)
//   div_load in   one-cycle strobe requesting div_val
//   clk_out  out  divided clock, registered
//   tick     out  one-clk pulse on the first clk cycle of each clk_out period
//   div_cur  out  ratio currently in effect
//   cfg_err  out  one-clk pulse when div_load carries div_val < 2
module clock_divider_n #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default
    $error("clock_divider_n: DEFAULT_DIV out of range [2, 2^CNT_W-1]");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             load_ok;
  logic             wrap;

  always_comb begin
    cnt_d     = cnt_q;
    div_cur_d = div_cur_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    pos_d     = 1'b0;
    tick_d    = 1'b0;
    load_ok   = div_load && (div_val >= TWO);
    cfg_err_d = div_load && (div_val < TWO);
    wrap      = (cnt_q == div_cur_q - ONE);

    if (en) begin
      if (wrap) begin
        cnt_d = '0;
        // A load landing on the wrap edge beats any older pending request.
        if (load_ok) begin
          div_cur_d = div_val;
          shadow_d  = div_val;
          pend_d    = 1'b0;
        end else if (pend_q) begin
          div_cur_d = shadow_q;
          pend_d    = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        if (load_ok) begin
          shadow_d = div_val;
          pend_d   = 1'b1;
        end
      end
      pos_d  = (cnt_d < (div_cur_d >> 1));
      tick_d = (cnt_d == '0);
    end else begin
      if (load_ok) begin
        div_cur_d = div_val;
        shadow_d  = div_val;
        pend_d    = 1'b0;
      end
      // Park on the terminal count of the ratio that will be in effect, so
      // the first enabled edge wraps and starts a fresh period.
      cnt_d = div_cur_d - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= DEF_DIV - ONE;
      div_cur_q <= DEF_DIV;
      shadow_q  <= DEF_DIV;
      pend_q    <= 1'b0;
      pos_q     <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      pos_q     <= pos_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q, neg_d;

  // Half-cycle delayed copy of the posedge output; only odd ratios need the
  // extra half clk of high time, so even ratios keep it cleared.
  always_comb begin
    neg_d = pos_q & div_cur_q[0];
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign clk_out = pos_q | neg_q;
`else
  assign clk_out = pos_q;
`endif

  assign tick    = tick_q;
  assign div_cur = div_cur_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clock_divider_n.sv
// tb/tb_clock_divider_n.sv - directed self-checking bench for clock_divider_n
module tb_clock_divider_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_cur;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  clock_divider_n #(.CNT_W(8), .DEFAULT_DIV(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_val  (div_val),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected clk_out just after the posedge that brings the period to phase ph.
  function automatic int exp_clk(input int n, input int ph);
    int hi;
    hi = (ph < n / 2) ? 1 : 0;
`ifdef CLK_DIV_ODD_DUTY50_EN
    if (n % 2 == 1) begin
      int pv;
      pv = (ph == 0) ? n - 1 : ph - 1;
      if (pv < n / 2) hi = 1;
    end
`endif
    return hi;
  endfunction

  // Advance cnt edges at ratio n starting from phase ph0, checking each cycle.
  task automatic run_n(input string tag, input int n, input int ph0, input int cnt);
    int ph;
    for (int i = 0; i < cnt; i++) begin
      ph = (ph0 + i) % n;
      @(posedge clk);
      #1;
      chk({tag, ".clk"}, int'(clk_out), exp_clk(n, ph));
      chk({tag, ".tick"}, int'(tick), (ph == 0) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    div_val  = 8'd0;
    div_load = 1'b0;

    // Reset state
    #13;
    chk("rst.clk", int'(clk_out), 0);
    chk("rst.tick", int'(tick), 0);
    chk("rst.div", int'(div_cur), 5);
    chk("rst.err", int'(cfg_err), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Default N=5 for 20 cycles: 11000 x4, tick every 5
    run_n("n5", 5, 0, 20);
    chk("n5.div", int'(div_cur), 5);

    // Invalid ratios: cfg_err pulses, ratio and waveform untouched
    div_load = 1'b1; div_val = 8'd1;
    run_n("err1", 5, 0, 1);
    chk("err1.err", int'(cfg_err), 1);
    chk("err1.div", int'(div_cur), 5);
    div_load = 1'b0;
    run_n("err1b", 5, 1, 1);
    chk("err1b.err", int'(cfg_err), 0);
    div_load = 1'b1; div_val = 8'd0;
    run_n("err0", 5, 2, 1);
    chk("err0.err", int'(cfg_err), 1);
    div_load = 1'b0;
    run_n("err0b", 5, 3, 2);
    chk("err0b.err", int'(cfg_err), 0);
    chk("err0b.div", int'(div_cur), 5);

    // Load 4 at cycle 2: current period completes at 5, then 1100
    run_n("ld4a", 5, 0, 2);
    div_load = 1'b1; div_val = 8'd4;
    run_n("ld4b", 5, 2, 1);
    div_load = 1'b0;
    chk("ld4.pend_div", int'(div_cur), 5);
    run_n("ld4c", 5, 3, 2);
    chk("ld4.old_div", int'(div_cur), 5);
    run_n("ld4d", 4, 0, 1);
    chk("ld4.new_div", int'(div_cur), 4);
    run_n("ld4e", 4, 1, 7);

    // Load on the wrap edge applies directly
    div_load = 1'b1; div_val = 8'd3;
    run_n("ldw", 3, 0, 1);
    chk("ldw.div", int'(div_cur), 3);

    // Back-to-back loads before a wrap: last one wins
    div_val = 8'd7;
    run_n("b2b1", 3, 1, 1);
    div_val = 8'd6;
    run_n("b2b2", 3, 2, 1);
    div_load = 1'b0;
    chk("b2b.old_div", int'(div_cur), 3);
    run_n("b2b3", 6, 0, 6);
    chk("b2b.div", int'(div_cur), 6);

    // Idle mid-period, load 2 while idle, re-enable
    en = 1'b0;
    @(posedge clk); #1;
    chk("idle1.clk", int'(clk_out), 0);
    chk("idle1.tick", int'(tick), 0);
    div_load = 1'b1; div_val = 8'd2;
    @(posedge clk); #1;
    div_load = 1'b0;
    chk("idle2.div", int'(div_cur), 2);
    chk("idle2.clk", int'(clk_out), 0);
    @(posedge clk); #1;
    chk("idle3.tick", int'(tick), 0);
    en = 1'b1;
    run_n("n2", 2, 0, 6);
    chk("n2.div", int'(div_cur), 2);

    // Move to N=8 at the wrap, then reset at cnt=3 with 7 pending
    div_load = 1'b1; div_val = 8'd8;
    run_n("n8a", 8, 0, 1);
    div_load = 1'b0;
    chk("n8.div", int'(div_cur), 8);
    run_n("n8b", 8, 1, 2);
    div_load = 1'b1; div_val = 8'd7;
    run_n("n8c", 8, 3, 1);
    div_load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.clk", int'(clk_out), 0);
    chk("arst.tick", int'(tick), 0);
    chk("arst.div", int'(div_cur), 5);
    #2;
    rst_n = 1'b1;
    run_n("post", 5, 0, 12);
    chk("post.div", int'(div_cur), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_divider_n.md
Name: clock_divider_n

Overview:
- Runtime-programmable integer clock divider. Generalises the fixed divide-by-5 generator to any ratio N in [2, 2^CNT_W-1].
- Produces a registered, glitch-free divided clock and a one-cycle tick usable as a clock enable in the clk domain.
- New ratios are loaded through a shadow register and take effect only at a period boundary.
- Sits beside the FIFO/datapath logic to generate slow strobes and derived clocks.

Parameters:
- CNT_W, 8: width of the counter and of the ratio registers. Max ratio is 2^CNT_W-1.
- DEFAULT_DIV, 5: ratio in effect after reset. Must lie in [2, 2^CNT_W-1]; out-of-range is an elaboration error.

Ports:
- clk      input   1      system clock
- rst_n    input   1      asynchronous active-low reset
- en       input   1      run enable; low holds the divider idle
- div_val  input   CNT_W  requested ratio N
- div_load input   1      one-cycle strobe; request ratio div_val
- clk_out  output  1      divided clock, registered
- tick     output  1      one-clk pulse on the first clk cycle of each clk_out period
- div_cur  output  CNT_W  ratio currently in effect
- cfg_err  output  1      one-clk pulse when div_load carries div_val < 2

Behaviour:
- Reset (async, rst_n=0):
  - cnt=DEFAULT_DIV-1, div_cur=DEFAULT_DIV, shadow=DEFAULT_DIV, pend=0.
  - clk_out=0, tick=0, cfg_err=0.
  - Release is synchronous to clk; no output changes until the first posedge after release.
- Running (en=1), each posedge:
  - If cnt==div_cur-1 (wrap): cnt<=0. If pend, div_cur<=shadow and pend<=0.
  - Otherwise cnt<=cnt+1.
  - Outputs are registered from the next-state values: clk_out<=(cnt_next < floor(div_next/2)), tick<=(cnt_next==0).
  - Reset parks cnt at the terminal value, so the first enabled edge wraps: clk_out=1, tick=1.
  - Resulting waveform:
    - N=5: clk_out 1,1,0,0,0 repeating.
    - N=4: clk_out 1,1,0,0.
    - N=2: clk_out 1,0.
    - Any N: tick high 1 cycle in every N.
- Ratio load:
  - div_load with div_val>=2 and en=1: shadow<=div_val, pend<=1. Applied at the next wrap; the current period completes at the old ratio.
  - div_load on the same edge as a wrap: div_val is applied directly at that wrap (div_cur<=div_val), and pend is cleared.
  - Back-to-back loads before a wrap: last one wins.
  - div_load with en=0: div_cur<=div_val immediately; shadow updated; pend=0.
  - div_val<2: request ignored (no register changes), cfg_err=1 for exactly one cycle.
- Idle (en=0): cnt<=div_cur-1, clk_out<=0, tick<=0 on the next edge. Re-enable restarts a fresh period with tick on the first enabled edge.
- Reset mid-period: outputs drop to reset values immediately (async); any pending load is discarded.
- Arithmetic: unsigned CNT_W. half=div>>1. No counter overflow is possible, since cnt<div<=2^CNT_W-1.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - Adds a negedge flop, reset by rst_n to 0, that samples the posedge clk_out register.
  - For odd div_cur, clk_out = pos_q | neg_q, giving exactly 50% duty. N=5: high 2.5 clk, low 2.5 clk.
  - For even div_cur, neg_q is forced 0 and the output equals the posedge register.
  - tick is unchanged.
- Undefined: clk_out is the posedge register only. Odd N gives high floor(N/2) cycles, low ceil(N/2) cycles.

Test Plan:
- Reset, then en=1, default N=5, 20 cycles -> clk_out 11000 repeated 4x; tick at cycles 0,5,10,15; div_cur=5.
- At cycle 2 of a N=5 period, div_load with div_val=4 -> current period finishes as 5 cycles; next periods are 1100; div_cur becomes 4 at the wrap edge.
- div_load with div_val=1, then with div_val=0 -> cfg_err pulses once per request; div_cur stays 5; waveform undisturbed.
- en=0 mid-period for 3 cycles, load N=2, then en=1 -> clk_out=0 and tick=0 while idle; div_cur=2 immediately; after re-enable clk_out 1010..., tick every 2 cycles.
- rst_n asserted at cnt=3 with a load pending (div_val=7) -> clk_out=0 and tick=0 asynchronously; after release, divides by 5 (DEFAULT_DIV) and the pending 7 is discarded.
- CLK_DIV_ODD_DUTY50_EN defined, N=5 then N=6 -> N=5: high time 2.5 clk periods per 5; N=6: high 3, low 3, no negedge contribution.
